divu_seq: RTL and testbench

//  Iterative unsigned divider for DIVU in the EX stage, beside Multiplier. Takes rs/rt operands

---
 rtl/divu_pkg.sv | 15 +
 rtl/divu_step.sv | 26 ++
 rtl/divu_seq.sv | 132 +++++++++++++
 tb/tb_divu_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package divu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/divu_step.sv
// One restoring shift-subtract iteration: shifts {rem, quot} left by one and
// subtracts the divisor from the partial remainder when it fits.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The compare needs the bit shifted out of rem; the low WIDTH bits of the
  // difference are exact whenever the subtraction is taken.
  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;

  assign o_rem  = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_quot = {i_quot[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divu_seq.sv
// Iterative unsigned divider (DIVU): one quotient bit per cycle, result as
// {remainder, quotient}, with a stall request while a division is in flight.
module divu_seq
  import divu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_flush,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div0,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_div0_pend;
  logic [2*WIDTH-1:0] r_result;
  logic               r_div0;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quot;
  logic               w_accept;
  logic               w_show;

  assign w_accept = (r_state == ST_IDLE) & i_start & ~i_flush;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (i_divisor == {WIDTH{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_flush) begin
          w_next = ST_IDLE;
        end else if (r_count == CW'(1)) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and iteration; a zero divisor preloads the final answer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_div0_pend <= 1'b0;
    end else if (w_accept) begin
      r_count   <= CW'(WIDTH);
      r_divisor <= i_divisor;
      if (i_divisor == {WIDTH{1'b0}}) begin
        r_rem       <= i_dividend;
        r_quot      <= WIDTH'(DIV0_QUOT);
        r_div0_pend <= 1'b1;
      end else begin
        r_rem       <= '0;
        r_quot      <= i_dividend;
        r_div0_pend <= 1'b0;
      end
    end else if ((r_state == ST_RUN) && !i_flush) begin
      r_rem   <= w_step_rem;
      r_quot  <= w_step_quot;
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // The visible result only commits when DONE completes unflushed, so an
  // aborted division never disturbs the last reported result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_div0   <= 1'b0;
    end else if (w_show) begin
      r_result <= {r_rem, r_quot};
      r_div0   <= r_div0_pend;
    end else begin
      r_result <= r_result;
      r_div0   <= r_div0;
    end
  end

  always_comb begin
    w_show   = (r_state == ST_DONE) & ~i_flush;
    o_done   = w_show;
    o_busy   = (r_state == ST_RUN);
    o_stall  = w_accept | (r_state == ST_RUN);
    o_result = w_show ? {r_rem, r_quot} : r_result;
    o_div0   = w_show ? r_div0_pend : r_div0;
  end

endmodule

// File: tb/tb_divu_seq.sv
// Randomized self-checking bench for divu_seq against a plain-arithmetic model.
module tb_divu_seq;

  localparam int W = 32;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_flush = 1'b0;
  logic [W-1:0]   i_dividend = '0;
  logic [W-1:0]   i_divisor = '0;
  logic           o_stall;
  logic           o_busy;
  logic           o_done;
  logic           o_div0;
  logic [2*W-1:0] o_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_result = '0;
  logic        exp_div0 = 1'b0;

  divu_seq #(.WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_flush    (i_flush),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_stall    (o_stall),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div0     (o_div0),
    .o_result   (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle 0 is the cycle start is driven; flush_at/restart_at < 0 disables them.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int restart_at);
    int          lat;
    bit          acc;
    bit          live;
    logic [63:0] res;
    logic        d0;
    lat = (b == 32'd0) ? 1 : W + 1;
    acc = (flush_at != 0);
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
      d0  = 1'b1;
    end else begin
      res = {a % b, a / b};
      d0  = 1'b0;
    end
    for (int cyc = 0; cyc <= lat + 2; cyc++) begin
      i_start    = (cyc == 0) || (cyc == restart_at);
      i_dividend = (cyc == restart_at) ? 32'd50 : a;
      i_divisor  = (cyc == restart_at) ? 32'd5 : b;
      i_flush    = (cyc == flush_at);
      #3;
      live = acc && !(flush_at > 0 && cyc > flush_at);
      check_eq("stall", {63'd0, o_stall}, {63'd0, live && cyc < lat});
      check_eq("busy", {63'd0, o_busy}, {63'd0, live && b != 32'd0 && cyc >= 1 && cyc < lat});
      check_eq("done", {63'd0, o_done}, {63'd0, live && cyc == lat && flush_at != cyc});
      if (live && cyc == lat && flush_at != cyc) begin
        exp_result = res;
        exp_div0   = d0;
      end
      check_eq("result", o_result, exp_result);
      check_eq("div0", {63'd0, o_div0}, {63'd0, exp_div0});
      @(posedge i_clk);
      #1;
    end
    i_start = 1'b0;
    i_flush = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    int          fa;

    #2;
    check_eq("rst_stall", {63'd0, o_stall}, 64'd0);
    check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
    check_eq("rst_done", {63'd0, o_done}, 64'd0);
    check_eq("rst_div0", {63'd0, o_div0}, 64'd0);
    check_eq("rst_result", o_result, 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    run_div(32'd100, 32'd7, -1, -1);
    run_div(32'd3, 32'd10, -1, -1);
    run_div(32'hFFFF_FFFF, 32'd1, -1, -1);
    run_div(32'd5, 32'd0, -1, -1);
    run_div(32'd100, 32'd7, 10, -1);
    run_div(32'd100, 32'd7, -1, 5);
    run_div(32'd77, 32'd4, 0, -1);
    run_div(32'd81, 32'd9, 33, -1);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run_div(32'd0, 32'd13, -1, -1);

    // Asynchronous reset in the middle of a division.
    i_start    = 1'b1;
    i_dividend = 32'd100;
    i_divisor  = 32'd7;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int k = 1; k < 12; k++) begin
      @(posedge i_clk);
      #1;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    exp_result = '0;
    exp_div0   = 1'b0;
    check_eq("arst_stall", {63'd0, o_stall}, 64'd0);
    check_eq("arst_busy", {63'd0, o_busy}, 64'd0);
    check_eq("arst_done", {63'd0, o_done}, 64'd0);
    check_eq("arst_div0", {63'd0, o_div0}, 64'd0);
    check_eq("arst_result", o_result, 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_div(32'd9, 32'd3, -1, -1);

    for (int it = 0; it < 24; it++) begin
      ra  = $urandom;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = ra;
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && sel != 0) rb = 32'd1;
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 33)) : -1;
      run_div(ra, rb, fa, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
